// File: rtl/rf_dump_reader.sv
// Register-file dump reader: walks a wrapped address range through a
// 1-cycle-latency read port and streams {addr, data} entries on valid/ready.
module rf_dump_reader #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned NUM_REGS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, issued_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic                rd_vld_q, rd_last_q;
  logic [ADDR_W-1:0]   rd_tag_q;
  logic                busy_q, done_q;

  // Two-entry buffer: head register drives the stream, tail is the skid slot.
  logic                h_vld_q, h_last_q, t_vld_q, t_last_q;
  logic [ADDR_W-1:0]   h_addr_q, t_addr_q;
  logic [DATA_W-1:0]   h_data_q, t_data_q;
  logic                h_vld_d, h_last_d, t_vld_d, t_last_d;
  logic [ADDR_W-1:0]   h_addr_d, t_addr_d;
  logic [DATA_W-1:0]   h_data_d, t_data_d;

  logic                pop, push, flush, last_issue;
  logic [2:0]          pend;

  assign rd_addr   = rd_ptr_q;
  assign out_valid = h_vld_q;
  assign out_addr  = h_addr_q;
  assign out_data  = h_data_q;
  assign out_last  = h_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state and read issue; a read goes out only when the buffer can absorb it.
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    flush      = 1'b0;
    pop        = h_vld_q & out_ready;
    push       = rd_vld_q;
    pend       = 3'(h_vld_q) + 3'(t_vld_q) + 3'(rd_vld_q) - 3'(pop);
    last_issue = (issued_q == count_q - CNT_W'(1));
    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_READ;
      end
      S_READ: begin
        if (abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (pend < 3'd2) begin
          rd_en = 1'b1;
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (pop && h_last_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Buffer update: pop shifts tail into head, push fills the first free slot.
  always_comb begin
    h_vld_d  = h_vld_q;
    h_addr_d = h_addr_q;
    h_data_d = h_data_q;
    h_last_d = h_last_q;
    t_vld_d  = t_vld_q;
    t_addr_d = t_addr_q;
    t_data_d = t_data_q;
    t_last_d = t_last_q;
    if (flush) begin
      h_vld_d = 1'b0;
      t_vld_d = 1'b0;
    end else begin
      if (pop) begin
        h_vld_d  = t_vld_q;
        h_addr_d = t_addr_q;
        h_data_d = t_data_q;
        h_last_d = t_last_q;
        t_vld_d  = 1'b0;
      end
      if (push) begin
        if (!h_vld_d) begin
          h_vld_d  = 1'b1;
          h_addr_d = rd_tag_q;
          h_data_d = rd_data;
          h_last_d = rd_last_q;
        end else begin
          t_vld_d  = 1'b1;
          t_addr_d = rd_tag_q;
          t_data_d = rd_data;
          t_last_d = rd_last_q;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Read pointer, issue counter, read pipeline tag, buffer and status flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      issued_q  <= '0;
      rd_ptr_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_tag_q  <= '0;
      rd_last_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      h_vld_q   <= 1'b0;
      h_addr_q  <= '0;
      h_data_q  <= '0;
      h_last_q  <= 1'b0;
      t_vld_q   <= 1'b0;
      t_addr_q  <= '0;
      t_data_q  <= '0;
      t_last_q  <= 1'b0;
    end else begin
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      rd_vld_q <= rd_en;
      if (state_q == S_IDLE && state_d == S_READ) begin
        rd_ptr_q <= dump_base;
        issued_q <= '0;
        count_q  <= (dump_count == '0) ? CNT_W'(NUM_REGS) : dump_count;
      end else if (rd_en) begin
        rd_tag_q  <= rd_ptr_q;
        rd_last_q <= last_issue;
        rd_ptr_q  <= (rd_ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
        issued_q  <= issued_q + CNT_W'(1);
      end
      h_vld_q  <= h_vld_d;
      h_addr_q <= h_addr_d;
      h_data_q <= h_data_d;
      h_last_q <= h_last_d;
      t_vld_q  <= t_vld_d;
      t_addr_q <= t_addr_d;
      t_data_q <= t_data_d;
      t_last_q <= t_last_d;
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: RF model with 1-cycle read latency, stream capture,
// and an expected-entry list built from base/count with modulo-128 addressing.
module tb_rf_dump_reader;

  typedef struct packed {
    logic [6:0]   a;
    logic [127:0] d;
    logic         l;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort, out_ready;
  logic [6:0]   dump_base;
  logic [7:0]   dump_count;
  logic         rd_en;
  logic [6:0]   rd_addr;
  logic [127:0] rd_data;
  logic         out_valid, out_last, busy, done;
  logic [6:0]   out_addr;
  logic [127:0] out_data;

  logic [127:0] rf [0:127];

  int tests = 0;
  int fails = 0;

  ent_t got_q[$];
  int k_first_v, k_last_hs, k_done, k_abort, n_done, n_rd, stall_err, rd_hold;
  int post_abort_valid, timeout;
  logic busy_after_abort, busy_post_done;

  rf_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dump_base(dump_base), .dump_count(dump_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file model: data appears the cycle after the read strobe.
  always @(posedge clk) if (rd_en) rd_data <= rf[rd_addr];

  // Runs one dump and records what the stream and status outputs did.
  // mode 0: ready high, 1: random ready, 2: toggling with a 5-cycle low hold.
  task automatic run_dump(input int base, input int cnt, input int mode,
                          input int abort_after, input int restart_k, input int budget);
    ent_t prev, cur;
    bit   stalled = 0;
    bit   aborted = 0;
    int   k = 0;
    got_q.delete();
    k_first_v = -1; k_last_hs = -1; k_done = -1; k_abort = -1;
    n_done = 0; n_rd = 0; stall_err = 0; rd_hold = 0; post_abort_valid = 0; timeout = 0;
    busy_after_abort = 1'bx; busy_post_done = 1'bx;
    prev = '0;
    dump_base = 7'(base); dump_count = 8'(cnt); start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (1) begin
      start = 1'b0; abort = 1'b0;
      if (k == restart_k) begin
        start = 1'b1; dump_base = 7'(base + 50); dump_count = 8'd5;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k >= 6 && k <= 10) ? 1'b0 : 1'(k % 2);
      endcase
      if (abort_after >= 0 && !aborted && got_q.size() == abort_after) begin
        abort = 1'b1; out_ready = 1'b0; aborted = 1; k_abort = k;
      end
      #1;
      cur.a = out_addr; cur.d = out_data; cur.l = out_last;
      if (rd_en) n_rd++;
      if (mode == 2 && k >= 8 && k <= 10 && rd_en) rd_hold++;
      if (out_valid && k_first_v < 0) k_first_v = k;
      if (stalled && (!out_valid || cur !== prev)) stall_err++;
      if (aborted && k > k_abort && out_valid) post_abort_valid++;
      if (aborted && k == k_abort + 1) busy_after_abort = busy;
      if (done) begin
        n_done++;
        if (k_done < 0) k_done = k;
      end
      if (k_done >= 0 && k == k_done + 1) busy_post_done = busy;
      if (out_valid && out_ready) begin
        got_q.push_back(cur);
        if (out_last) k_last_hs = k;
      end
      stalled = out_valid && !out_ready;
      prev = cur;
      if ((k_done >= 0 && k >= k_done + 2) || (aborted && k >= k_abort + 6)) break;
      if (k >= budget) begin
        timeout = 1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0; start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    dump_base = '0; dump_count = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({rd_en, out_valid, out_last, busy, done} !== 5'b0) begin
      $display("FAIL reset_flags: got %b, want 00000", {rd_en, out_valid, out_last, busy, done}); fails++;
    end
    tests++;
    if ({rd_addr, out_addr, out_data} !== '0) begin
      $display("FAIL reset_data: got rd_addr=%0d out_addr=%0d out_data=%h, want 0", rd_addr, out_addr, out_data); fails++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy, rd_en} !== 2'b00) begin
      $display("FAIL reset_idle: got busy,rd_en=%b, want 00", {busy, rd_en}); fails++;
    end
  endtask

  task automatic test_reset_mid_read();
    int base = int'($urandom_range(0, 127));
    int g = 0;
    dump_base = 7'(base); dump_count = 8'd20; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (out_valid) g++;
      @(posedge clk); #1;
      if (g == 3) break;
    end
    tests++;
    if (g != 3) begin
      $display("FAIL midrst_entries: got %0d, want 3", g); fails++;
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin $display("FAIL midrst_valid: got %b, want 0", out_valid); fails++; end
    tests++;
    if ({rd_en, busy, done} !== 3'b0) begin $display("FAIL midrst_ctrl: got %b, want 000", {rd_en, busy, done}); fails++; end
    tests++;
    if ({rd_addr, out_addr, out_data, out_last} !== '0) begin
      $display("FAIL midrst_data: got rd_addr=%0d out_addr=%0d last=%b, want 0", rd_addr, out_addr, out_last); fails++;
    end
    #1 rst = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, busy} !== 2'b00) begin $display("FAIL midrst_after: got %b, want 00", {out_valid, busy}); fails++; end
    run_dump(base, 6, 0, -1, -1, 80);
    tests++;
    if (got_q.size() != 6 || timeout != 0) begin
      $display("FAIL midrst_restart_n: got %0d entries timeout=%0d, want 6", got_q.size(), timeout); fails++;
    end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      ent_t e;
      e.a = 7'((base + i) % 128); e.d = rf[e.a]; e.l = (i == 5);
      tests++;
      if (got_q[i] !== e) begin
        $display("FAIL midrst_entry%0d: got a=%0d l=%b d=%h, want a=%0d l=%b d=%h", i, got_q[i].a, got_q[i].l, got_q[i].d, e.a, e.l, e.d); fails++;
      end
    end
  endtask

  task automatic test_full_dump();
    int bad = 0;
    run_dump(0, 0, 0, -1, -1, 400);
    tests++;
    if (got_q.size() != 128 || timeout != 0) begin
      $display("FAIL full_n: got %0d entries timeout=%0d, want 128", got_q.size(), timeout); fails++;
    end
    for (int i = 0; i < got_q.size() && i < 128; i++) begin
      ent_t e;
      e.a = 7'(i); e.d = rf[i]; e.l = (i == 127);
      if (got_q[i] !== e) begin
        bad++;
        $display("FAIL full_entry%0d: got a=%0d l=%b, want a=%0d l=%b", i, got_q[i].a, got_q[i].l, e.a, e.l);
      end
    end
    tests++;
    if (bad != 0) begin $display("FAIL full_entries: got %0d bad entries, want 0", bad); fails++; end
    tests++;
    if (k_first_v != 2) begin $display("FAIL full_latency: got first valid at %0d, want 2", k_first_v); fails++; end
    tests++;
    if (k_last_hs != k_first_v + 127) begin
      $display("FAIL full_throughput: got last handshake %0d, want %0d", k_last_hs, k_first_v + 127); fails++;
    end
    tests++;
    if (n_done != 1 || k_done != k_last_hs + 1) begin
      $display("FAIL full_done: got %0d pulses at %0d, want 1 at %0d", n_done, k_done, k_last_hs + 1); fails++;
    end
    tests++;
    if (busy_post_done !== 1'b0) begin $display("FAIL full_busy_end: got %b, want 0", busy_post_done); fails++; end
    tests++;
    if (n_rd != 128) begin $display("FAIL full_reads: got %0d, want 128", n_rd); fails++; end
  endtask

  task automatic test_wrap();
    run_dump(126, 4, 0, -1, -1, 60);
    tests++;
    if (got_q.size() != 4 || timeout != 0) begin
      $display("FAIL wrap_n: got %0d entries timeout=%0d, want 4", got_q.size(), timeout); fails++;
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      ent_t e;
      e.a = 7'((126 + i) % 128); e.d = rf[e.a]; e.l = (i == 3);
      tests++;
      if (got_q[i] !== e) begin
        $display("FAIL wrap_entry%0d: got a=%0d l=%b, want a=%0d l=%b", i, got_q[i].a, got_q[i].l, e.a, e.l); fails++;
      end
    end
    tests++;
    if (n_done != 1) begin $display("FAIL wrap_done: got %0d pulses, want 1", n_done); fails++; end
  endtask

  task automatic test_backpressure();
    int base = int'($urandom_range(0, 127));
    run_dump(base, 8, 2, -1, -1, 120);
    tests++;
    if (got_q.size() != 8 || timeout != 0) begin
      $display("FAIL bp_n: got %0d entries timeout=%0d, want 8", got_q.size(), timeout); fails++;
    end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      ent_t e;
      e.a = 7'((base + i) % 128); e.d = rf[e.a]; e.l = (i == 7);
      tests++;
      if (got_q[i] !== e) begin
        $display("FAIL bp_entry%0d: got a=%0d l=%b, want a=%0d l=%b", i, got_q[i].a, got_q[i].l, e.a, e.l); fails++;
      end
    end
    tests++;
    if (stall_err != 0) begin $display("FAIL bp_stable: got %0d changes while stalled, want 0", stall_err); fails++; end
    tests++;
    if (rd_hold != 0) begin $display("FAIL bp_rd_stop: got %0d reads during hold, want 0", rd_hold); fails++; end
    tests++;
    if (n_rd != 8) begin $display("FAIL bp_reads: got %0d, want 8", n_rd); fails++; end
    tests++;
    if (n_done != 1 || k_done != k_last_hs + 1) begin
      $display("FAIL bp_done: got %0d pulses at %0d, want 1 at %0d", n_done, k_done, k_last_hs + 1); fails++;
    end
  endtask

  task automatic test_abort();
    int base = int'($urandom_range(0, 127));
    run_dump(base, 10, 0, 2, -1, 60);
    tests++;
    if (got_q.size() != 2 || k_abort < 0) begin
      $display("FAIL abort_n: got %0d entries abort_at=%0d, want 2", got_q.size(), k_abort); fails++;
    end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      ent_t e;
      e.a = 7'((base + i) % 128); e.d = rf[e.a]; e.l = 1'b0;
      tests++;
      if (got_q[i] !== e) begin
        $display("FAIL abort_entry%0d: got a=%0d l=%b, want a=%0d l=%b", i, got_q[i].a, got_q[i].l, e.a, e.l); fails++;
      end
    end
    tests++;
    if (post_abort_valid != 0) begin $display("FAIL abort_valid: got %0d valid cycles after abort, want 0", post_abort_valid); fails++; end
    tests++;
    if (n_done != 0) begin $display("FAIL abort_done: got %0d pulses, want 0", n_done); fails++; end
    tests++;
    if (busy_after_abort !== 1'b0) begin $display("FAIL abort_busy: got %b, want 0", busy_after_abort); fails++; end
  endtask

  task automatic test_start_while_busy();
    run_dump(10, 6, 0, -1, 3, 60);
    tests++;
    if (got_q.size() != 6 || timeout != 0) begin
      $display("FAIL restart_n: got %0d entries timeout=%0d, want 6", got_q.size(), timeout); fails++;
    end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      ent_t e;
      e.a = 7'(10 + i); e.d = rf[e.a]; e.l = (i == 5);
      tests++;
      if (got_q[i] !== e) begin
        $display("FAIL restart_entry%0d: got a=%0d l=%b, want a=%0d l=%b", i, got_q[i].a, got_q[i].l, e.a, e.l); fails++;
      end
    end
    run_dump(77, 1, 0, -1, -1, 40);
    tests++;
    if (got_q.size() != 1) begin $display("FAIL single_n: got %0d entries, want 1", got_q.size()); fails++; end
    else begin
      ent_t e;
      e.a = 7'd77; e.d = rf[77]; e.l = 1'b1;
      tests++;
      if (got_q[0] !== e) begin
        $display("FAIL single_entry: got a=%0d l=%b, want a=%0d l=1", got_q[0].a, got_q[0].l, e.a); fails++;
      end
    end
    tests++;
    if (n_done != 1 || n_rd != 1) begin $display("FAIL single_done: got done=%0d reads=%0d, want 1 1", n_done, n_rd); fails++; end
  endtask

  task automatic test_start_abort_idle();
    int rds = 0;
    dump_base = 7'd5; dump_count = 8'd4; start = 1'b1; abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rd_en || out_valid) rds++;
      @(posedge clk); #1;
    end
    tests++;
    if (busy !== 1'b0 || rds != 0) begin $display("FAIL start_abort: got busy=%b activity=%0d, want 0 0", busy, rds); fails++; end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int base = int'($urandom_range(0, 127));
      int cnt  = int'($urandom_range(1, 40));
      int bad  = 0;
      run_dump(base, cnt, 1, -1, -1, cnt * 10 + 40);
      tests++;
      if (got_q.size() != cnt || timeout != 0) begin
        $display("FAIL rand%0d_n: got %0d entries timeout=%0d, want %0d", it, got_q.size(), timeout, cnt); fails++;
      end
      for (int i = 0; i < got_q.size() && i < cnt; i++) begin
        ent_t e;
        e.a = 7'((base + i) % 128); e.d = rf[e.a]; e.l = (i == cnt - 1);
        if (got_q[i] !== e) bad++;
      end
      tests++;
      if (bad != 0 || stall_err != 0) begin
        $display("FAIL rand%0d_entries: got %0d bad, %0d unstable, want 0 0", it, bad, stall_err); fails++;
      end
      tests++;
      if (n_done != 1 || n_rd != cnt) begin
        $display("FAIL rand%0d_done: got done=%0d reads=%0d, want 1 %0d", it, n_done, n_rd, cnt); fails++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rf[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_reset_mid_read();
    test_full_dump();
    test_wrap();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_start_abort_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
